switch_debounce: RTL
====================

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 Parameter WIDTH, default 8: number of switch inputs debounced.
REQ-002 Parameter STABLE_CYCLES, default 50000: consecutive agreeing samples required to accept a new level; legal range 1..65535.
REQ-003 Parameter CNT_WIDTH, default 16: width of each per-bit counter; SHALL hold STABLE_CYCLES-1.
REQ-004 i_clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 i_reset  input  1  synchronous, active-high reset, sampled on i_clk rising edge.
REQ-006 i_Switch  input  WIDTH  raw asynchronous switch levels, bouncing.
REQ-007 o_Switch  output  WIDTH  debounced stable levels; feeds the seven-segment display stage.
REQ-008 o_Rise  output  WIDTH  per-bit one-cycle pulse: o_Switch bit went 0->1 this cycle.
REQ-009 o_Fall  output  WIDTH  per-bit one-cycle pulse: o_Switch bit went 1->0 this cycle.
REQ-010 o_Changed  output  1  one-cycle pulse, OR of all o_Rise and o_Fall bits.
REQ-011 o_Idle  output  1  high when every per-bit counter is zero (no candidate change pending).

Function
REQ-012 Each i_Switch bit SHALL pass through two flip-flops (sync1, sync2) before any other use; no combinational path from i_Switch to any output.
REQ-013 Per bit, state SHALL be {stable level S, counter C}; the compared sample is sync2.
REQ-014 Edge with sync2 == S: C SHALL clear to 0; S unchanged.
REQ-015 Edge with sync2 != S and C < STABLE_CYCLES-1: C SHALL increment by 1; S unchanged.
REQ-016 Edge with sync2 != S and C == STABLE_CYCLES-1: S SHALL take sync2, C SHALL clear to 0, and the matching o_Rise/o_Fall bit SHALL be 1 for exactly that cycle.
REQ-017 Any single disagreeing sample (bounce) during a count SHALL restart the count from 0; partial counts are never kept.
REQ-018 C SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-019 STABLE_CYCLES == 1: S SHALL follow sync2 on the first disagreeing sample.
REQ-020 Latency: for a clean level change on i_Switch first sampled at edge 0, o_Switch SHALL change after edge STABLE_CYCLES+1.
REQ-021 Bits SHALL be independent; simultaneous changes on several bits SHALL each complete per REQ-016, and pulses on several bits in the same cycle are legal.
REQ-022 o_Switch, o_Rise, o_Fall, o_Changed, o_Idle SHALL all be registered outputs.
REQ-023 o_Changed SHALL assert in the same cycle as the o_Rise/o_Fall bits it summarises.
REQ-024 o_Idle SHALL be 0 in any cycle where at least one C is nonzero.

Reset
REQ-025 i_reset high SHALL take priority over all updates in REQ-014..REQ-016.
REQ-026 On reset: sync1, sync2, S and C of every bit SHALL be 0; o_Switch = 0; o_Rise = o_Fall = 0; o_Changed = 0; o_Idle = 1.
REQ-027 Reset asserted mid-count SHALL discard the count and suppress any pending pulse; after release, an input held high SHALL need the full REQ-020 latency before o_Switch shows it.

Verification (WIDTH=8, STABLE_CYCLES=4)
REQ-028 Reset, i_Switch=0x00 -> o_Switch=0x00, o_Rise=o_Fall=0x00, o_Changed=0, o_Idle=1 on every cycle.
REQ-029 i_Switch 0x00->0xA5 clean, first sampled at edge 0 -> o_Switch=0xA5 after edge 5; o_Rise=0xA5 and o_Changed=1 only in that cycle; o_Idle=0 from after edge 2 to after edge 4.
REQ-030 Bit 0 bounces 1,0,1,0 on consecutive edges then holds 1 -> o_Switch[0] stays 0 during the bounce, goes 1 exactly 5 edges after the final 0->1; single o_Rise[0] pulse.
REQ-031 From 0xFF, i_Switch->0x0F -> o_Fall=0xF0, o_Rise=0x00, one o_Changed pulse, o_Switch=0x0F.
REQ-032 i_Switch held 0x01, reset pulsed at edge 3 of a count -> no pulse; o_Switch=0x00 through reset; o_Switch=0x01 exactly STABLE_CYCLES+2 edges after reset deasserts.
REQ-033 Bit 7 rises at edge 0, bit 3 falls at edge 2 -> o_Rise=0x80 after edge 5, o_Fall=0x08 after edge 7, two separate o_Changed pulses.

Source files
------------

// File: rtl/switch_debounce.sv
// switch_debounce -- multi-bit mechanical switch debouncer.
//
// Each switch bit is synchronised through two flops. A per-bit counter then
// tracks how many consecutive samples disagree with the accepted level. A new
// level is accepted only after STABLE_CYCLES agreeing samples. Edge pulses are
// produced for the display stage.
//
// Parameters
//   WIDTH          number of switch inputs
//   STABLE_CYCLES  consecutive disagreeing samples needed to accept a level (1..65535)
//   CNT_WIDTH      per-bit counter width, must hold STABLE_CYCLES-1
// Ports
//   i_clk      clock, all state on rising edge
//   i_reset    synchronous active-high reset
//   i_Switch   raw bouncing switch levels
//   o_Switch   debounced levels (registered)
//   o_Rise     per-bit one-cycle 0->1 pulse of o_Switch
//   o_Fall     per-bit one-cycle 1->0 pulse of o_Switch
//   o_Changed  one-cycle OR of all o_Rise/o_Fall bits
//   o_Idle     high when no per-bit counter is running

// Per-bit debounce lane: synchroniser, stable level, counter, edge pulses.
// o_nxt_idle / o_nxt_edge are the combinational next-state summaries the top
// level registers into o_Idle / o_Changed so they line up with this lane's
// registered outputs.
module switch_debounce_bit #(
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_WIDTH     = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_nxt_idle,
    output logic o_nxt_edge
);

    localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LP_ONE  = CNT_WIDTH'(1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_level;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_rise;
    logic                 r_fall;

    logic                 w_level_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 w_rise_nxt;
    logic                 w_fall_nxt;

    always_comb begin
        w_level_nxt = r_level;
        w_cnt_nxt   = '0;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        if (r_sync2 != r_level) begin
            if (r_cnt == LP_LAST) begin
                // Enough agreeing samples: accept the new level.
                w_level_nxt = r_sync2;
                w_rise_nxt  = r_sync2;
                w_fall_nxt  = ~r_sync2;
            end else begin
                w_cnt_nxt = r_cnt + LP_ONE;
            end
        end
        // A sample matching the stable level leaves w_cnt_nxt at 0, which is
        // what throws away any partial count on a bounce.
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_level <= w_level_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    assign o_level    = r_level;
    assign o_rise     = r_rise;
    assign o_fall     = r_fall;
    assign o_nxt_idle = (w_cnt_nxt == '0);
    assign o_nxt_edge = w_rise_nxt | w_fall_nxt;

endmodule

module switch_debounce #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_WIDTH     = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_Switch,
    output logic [WIDTH-1:0] o_Switch,
    output logic [WIDTH-1:0] o_Rise,
    output logic [WIDTH-1:0] o_Fall,
    output logic             o_Changed,
    output logic             o_Idle
);

    logic [WIDTH-1:0] w_nxt_idle;
    logic [WIDTH-1:0] w_nxt_edge;
    logic             r_changed;
    logic             r_idle;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        switch_debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_WIDTH     (CNT_WIDTH)
        ) u_bit (
            .i_clk      (i_clk),
            .i_reset    (i_reset),
            .i_raw      (i_Switch[g]),
            .o_level    (o_Switch[g]),
            .o_rise     (o_Rise[g]),
            .o_fall     (o_Fall[g]),
            .o_nxt_idle (w_nxt_idle[g]),
            .o_nxt_edge (w_nxt_edge[g])
        );
    end

    // Summaries are registered from the lanes' next-state values so they
    // assert in the same cycle as the per-bit registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_changed <= 1'b0;
            r_idle    <= 1'b1;
        end else begin
            r_changed <= |w_nxt_edge;
            r_idle    <= &w_nxt_idle;
        end
    end

    assign o_Changed = r_changed;
    assign o_Idle    = r_idle;

endmodule
